// File: rtl/buf_pipe_gea.sv
// buf_pipe_gea: DEPTH-stage ready/valid pipeline buffer with bubble collapsing, flush and occupancy count.
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   upstream offers in_data
//   in_ready   out  buffer accepts in_data this cycle
//   in_data    in   [WIDTH] upstream data
//   out_valid  out  last stage holds valid data
//   out_ready  in   downstream accepts out_data
//   out_data   out  [WIDTH] data of last stage
//   flush      in   synchronous clear of all stage valids
//   count      out  [CW] number of valid stages
module buf_pipe_gea #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
);
    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [DEPTH-1:0] w_ld;
    logic             w_adv;
    logic [DEPTH:0]   w_cat;
    logic [WIDTH-1:0] w_nd [DEPTH];

    // Ready chain from the output side: a stage loads when it is empty or the
    // stage ahead of it moves, and that load is in turn the advance of the stage behind.
    always_comb begin
        w_adv = out_ready;
        w_ld  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_ld[k] = !r_v[k] | w_adv;
            w_adv   = w_ld[k];
        end
    end

    assign in_ready = w_ld[0] & !flush;
    // Valid source of each stage: accepted input for stage 0, previous stage otherwise.
    assign w_cat    = {r_v, in_valid & in_ready};

    always_comb begin
        w_nd[0] = in_data;
        for (int k = 1; k < DEPTH; k++)
            w_nd[k] = r_d[k-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_d[k] <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (w_ld[k]) begin
                    r_v[k] <= w_cat[k];
                    r_d[k] <= w_nd[k];
                end
        end
    end

    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign count     = CW'($countones(r_v));
endmodule

// File: tb/tb_buf_pipe_gea.sv
// tb_buf_pipe_gea: vector table, directed corner cases and random traffic against a word-position model.
module tb_buf_pipe_gea;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 0;
    logic         reset_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [W-1:0] out_data;
    logic         flush = 0;
    logic [2:0]   count;

    buf_pipe_gea #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the words in flight, oldest first, each with the stage it sits in.
    typedef struct { logic [W-1:0] d; int p; } item_t;
    item_t q[$];

    logic         obs_ir, obs_ov;
    logic [W-1:0] obs_od;
    int           obs_cnt;

    typedef struct {
        bit iv; logic [W-1:0] d; bit ordy; bit fl;
        bit e_ir; bit e_ov; logic [W-1:0] e_od; int e_cnt;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word moves forward one stage unless the word ahead cannot make room;
    // the head leaves when it is in the last stage and out_ready is high.
    task automatic model_edge(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        bit acc;
        int lim;
        item_t nq[$];
        acc = iv && !fl && (q.size() < D || ordy);
        if (fl) begin
            q.delete();
            return;
        end
        lim = ordy ? D + 1 : D;
        foreach (q[i]) begin
            int np;
            np = (q[i].p + 1 < lim - 1) ? q[i].p + 1 : lim - 1;
            lim = np;
            if (np < D) nq.push_back('{d: q[i].d, p: np});
        end
        if (acc) nq.push_back('{d: d, p: 0});
        q = nq;
    endtask

    // One cycle: drive at the falling edge, check against the model, then clock.
    task automatic cyc(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        bit m_ov;
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        #1;
        obs_ir = in_ready; obs_ov = out_valid; obs_od = out_data; obs_cnt = int'(count);
        m_ov = q.size() > 0 && q[0].p == D - 1;
        chk("in_ready", int'(in_ready), int'(!fl && (q.size() < D || ordy)));
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("count", int'(count), q.size());
        if (m_ov) chk("out_data", int'(out_data), int'(q[0].d));
        @(posedge clk);
        model_edge(iv, d, ordy, fl);
        @(negedge clk);
    endtask

    initial begin
        tv[0]  = '{1, 8'hA0, 0, 0, 1, 0, 8'h00, 0};
        tv[1]  = '{1, 8'hA1, 0, 0, 1, 0, 8'h00, 1};
        tv[2]  = '{1, 8'hA2, 0, 0, 1, 0, 8'h00, 2};
        tv[3]  = '{1, 8'hA3, 0, 0, 1, 0, 8'h00, 3};
        tv[4]  = '{1, 8'hA4, 0, 0, 0, 1, 8'hA0, 4};
        tv[5]  = '{1, 8'hA4, 1, 0, 1, 1, 8'hA0, 4};
        tv[6]  = '{1, 8'hA5, 1, 0, 1, 1, 8'hA1, 4};
        tv[7]  = '{0, 8'h00, 1, 0, 1, 1, 8'hA2, 4};
        tv[8]  = '{0, 8'h00, 1, 0, 1, 1, 8'hA3, 3};
        tv[9]  = '{0, 8'h00, 1, 0, 1, 1, 8'hA4, 2};
        tv[10] = '{0, 8'h00, 1, 0, 1, 1, 8'hA5, 1};
        tv[11] = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 0};

        // Reset state
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // Fill and stall, then drain
        for (int i = 0; i < 12; i++) begin
            cyc(tv[i].iv, tv[i].d, tv[i].ordy, tv[i].fl);
            chk($sformatf("tv%0d_in_ready", i), int'(obs_ir), int'(tv[i].e_ir));
            chk($sformatf("tv%0d_out_valid", i), int'(obs_ov), int'(tv[i].e_ov));
            if (tv[i].e_ov) chk($sformatf("tv%0d_out_data", i), int'(obs_od), int'(tv[i].e_od));
            chk($sformatf("tv%0d_count", i), obs_cnt, tv[i].e_cnt);
        end

        // Streaming, then full with simultaneous in/out
        for (int i = 0; i < 14; i++) begin
            cyc(1, W'(i + 1), 1, 0);
            if (i >= 4) begin
                chk("stream_data", int'(obs_od), i - 3);
                chk("stream_count", obs_cnt, 4);
            end
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);

        // Bubble collapse
        cyc(1, 8'h55, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, W'(8'h60 + i), 0, 0);
            chk("bubble_in_ready", int'(obs_ir), 1);
        end
        chk("bubble_count", int'(count), 4);
        chk("bubble_head", int'(out_data), 8'h55);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);

        // Flush with count=3 and a stalled output
        for (int i = 0; i < 3; i++) cyc(1, W'(8'h70 + i), 0, 0);
        cyc(1, 8'hFF, 0, 1);
        chk("flush_in_ready", int'(obs_ir), 0);
        chk("flush_count_before", obs_cnt, 3);
        chk("flush_count_after", int'(count), 0);
        chk("flush_out_valid_after", int'(out_valid), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 0);
            chk("flush_no_ff", int'(obs_ov && obs_od == 8'hFF), 0);
        end

        // Asynchronous reset mid-stream with count=3
        for (int i = 0; i < 3; i++) cyc(1, W'(8'h80 + i), 0, 0);
        chk("pre_reset_count", int'(count), 3);
        in_valid = 0; flush = 0;
        #2 reset_n = 0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        q.delete();
        @(negedge clk);
        reset_n = 1;

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 31) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
